// File: rtl/imem_loader_pkg.sv
// Shared CPU constants: instruction width, bytes per word and the loader FSM encoding.
package imem_loader_pkg;
  localparam int INSTR_W    = 32;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/imem_loader.sv
// Streams bytes into 32-bit little-endian words and writes them into an instruction RAM.
// Handshake: a byte moves on a rising edge where ByteValid && ByteReady; ByteValid low simply stalls.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          MEM_WORDS = 64
) (
  input  logic               CLK,
  input  logic               Reset_L,
  input  logic               Start,
  input  logic [15:0]        WordCount,
  input  logic               Abort,
  input  logic [7:0]         ByteIn,
  input  logic               ByteValid,
  output logic               ByteReady,
  output logic               WrEn,
  output logic [63:0]        WrAddr,
  output logic [INSTR_W-1:0] WrData,
  output logic               Busy,
  output logic               Done,
  output logic               Error,
  output logic [1:0]         DbgState
);

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] words;
  logic [63:0] addr;
  logic [1:0]  idx;
  logic [23:0] shreg;
  logic [15:0] words_next;

  assign words_next = words + 16'd1;
  assign ByteReady  = (state == S_COLLECT);
  assign Busy       = (state == S_COLLECT) || (state == S_WRITE);
  // An abort landing in WRITE suppresses the strobe in that same cycle.
  assign WrEn       = (state == S_WRITE) && !Abort;
  assign DbgState   = state;

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state  <= S_IDLE;
      cnt    <= '0;
      words  <= '0;
      addr   <= BASE_ADDR;
      idx    <= '0;
      shreg  <= '0;
      WrAddr <= BASE_ADDR;
      WrData <= '0;
      Done   <= 1'b0;
      Error  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            cnt   <= WordCount;
            addr  <= BASE_ADDR;
            idx   <= '0;
            words <= '0;
            Done  <= 1'b0;
            Error <= 1'b0;
            if (WordCount == 16'd0) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else if (int'({16'd0, WordCount}) > MEM_WORDS) begin
              state <= S_DONE;
              Done  <= 1'b1;
              Error <= 1'b1;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        S_COLLECT: begin
          if (Abort) begin
            state <= S_DONE;
            Done  <= 1'b1;
            Error <= 1'b1;
            idx   <= '0;
          end else if (ByteValid) begin
            idx <= idx + 2'd1;
            case (idx)
              2'd0: shreg[7:0]   <= ByteIn;
              2'd1: shreg[15:8]  <= ByteIn;
              2'd2: shreg[23:16] <= ByteIn;
              default: begin
                WrData <= {ByteIn, shreg};
                WrAddr <= addr;
                state  <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          if (Abort) begin
            state <= S_DONE;
            Done  <= 1'b1;
            Error <= 1'b1;
            idx   <= '0;
          end else begin
            addr  <= addr + 64'(WORD_BYTES);
            words <= words_next;
            if (words_next == cnt) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state <= S_COLLECT;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected (addr, data) pairs queued by the driver, popped on WrEn.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [63:0] BASE = 64'h0;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic        Start;
  logic [15:0] WordCount;
  logic        Abort;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        WrEn;
  logic [63:0] WrAddr;
  logic [31:0] WrData;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [1:0]  DbgState;

  imem_loader #(.BASE_ADDR(BASE), .MEM_WORDS(64)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .Start(Start), .WordCount(WordCount), .Abort(Abort),
    .ByteIn(ByteIn), .ByteValid(ByteValid), .ByteReady(ByteReady), .WrEn(WrEn),
    .WrAddr(WrAddr), .WrData(WrData), .Busy(Busy), .Done(Done), .Error(Error),
    .DbgState(DbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [95:0] exp_q[$];
  int          wr_cyc_q[$];
  int          wr_count = 0;
  int          start_cyc = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge CLK) begin
    if (WrEn === 1'b1) begin
      logic [95:0] e;
      wr_count++;
      wr_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", WrAddr, e[95:32]);
        check("wr_data", WrData, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic do_start(input int wc);
    Start     = 1'b1;
    WordCount = 16'(wc);
    start_cyc = cyc;
    tick();
    Start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall, input bit chk_rdy);
    bit ok = 0;
    if (stall > 0) begin
      ByteValid = 1'b0;
      for (int s = 0; s < stall; s++) begin
        if (chk_rdy) check("stall_ready", ByteReady, 1);
        tick();
      end
    end
    ByteValid = 1'b1;
    ByteIn    = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (ByteReady) ok = 1;
      tick();
    end
    if (!ok) check("byte_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (Done) ok = 1;
      else tick();
    end
    if (!ok) check("done_timeout", 0, 1);
  endtask

  task automatic load_words(input int wc, input int max_stall);
    logic [31:0] w;
    do_start(wc);
    for (int n = 0; n < wc; n++) begin
      w = $urandom;
      exp_q.push_back({BASE + 64'(4 * n), w});
      for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(0, max_stall), 0);
    end
    ByteValid = 1'b0;
    wait_done();
    check("load_err", Error, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] b40[8];
    int base_wr;
    b40 = '{8'hE9, 8'h03, 8'h40, 8'hF8, 8'hEA, 8'h83, 8'h40, 8'hF8};
    Reset_L = 1'b0; Start = 1'b0; WordCount = '0; Abort = 1'b0; ByteIn = '0; ByteValid = 1'b0;
    repeat (2) tick();
    check("rst_ready", ByteReady, 0);
    check("rst_wren", WrEn, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_error", Error, 0);
    check("rst_addr", WrAddr, BASE);
    check("rst_data", WrData, 0);
    check("rst_state", DbgState, S_IDLE);
    Reset_L = 1'b1;
    tick();

    // abort while idle is ignored
    Abort = 1'b1; tick(); Abort = 1'b0;
    check("idle_abort_done", Done, 0);
    check("idle_abort_err", Error, 0);
    check("idle_abort_state", DbgState, S_IDLE);

    // two words, ByteValid held high
    wr_cyc_q.delete(); base_wr = wr_count;
    exp_q.push_back({64'h0, 32'hF84003E9});
    exp_q.push_back({64'h4, 32'hF84083EA});
    do_start(2);
    for (int i = 0; i < 8; i++) send_byte(b40[i], 0, 0);
    ByteValid = 1'b0;
    wait_done();
    check("w2_done", Done, 1);
    check("w2_error", Error, 0);
    check("w2_count", wr_count - base_wr, 2);
    check("w2_cyc0", wr_cyc_q[0], start_cyc + 5);
    check("w2_cyc1", wr_cyc_q[1], start_cyc + 10);

    // stall of three cycles between the second and third byte
    wr_cyc_q.delete(); base_wr = wr_count;
    exp_q.push_back({64'h0, 32'hD2E24689});
    do_start(1);
    send_byte(8'h89, 0, 1);
    send_byte(8'h46, 0, 1);
    send_byte(8'hE2, 3, 1);
    send_byte(8'hD2, 0, 1);
    ByteValid = 1'b0;
    wait_done();
    check("stall_count", wr_count - base_wr, 1);
    check("stall_cyc", wr_cyc_q[0], start_cyc + 8);
    check("hold_data", WrData, 32'hD2E24689);
    check("hold_addr", WrAddr, 64'h0);
    check("hold_wren", WrEn, 0);

    // zero words: done one cycle after start, no write
    base_wr = wr_count;
    do_start(0);
    check("wc0_done", Done, 1);
    check("wc0_error", Error, 0);
    check("wc0_busy", Busy, 0);
    repeat (3) tick();
    check("wc0_nowr", wr_count - base_wr, 0);

    // more words than the RAM holds
    do_start(65);
    check("ovf_done", Done, 1);
    check("ovf_error", Error, 1);
    repeat (3) tick();
    check("ovf_nowr", wr_count - base_wr, 0);

    // abort partway into the second word
    base_wr = wr_count;
    exp_q.push_back({64'h0, 32'h11223344});
    do_start(3);
    check("restart_clr_done", Done, 0);
    check("restart_clr_err", Error, 0);
    send_byte(8'h44, 0, 0); send_byte(8'h33, 0, 0);
    send_byte(8'h22, 0, 0); send_byte(8'h11, 0, 0);
    send_byte(8'hAA, 0, 0); send_byte(8'hBB, 0, 0);
    ByteValid = 1'b0;
    Start = 1'b1; WordCount = 16'd0; tick(); Start = 1'b0;
    check("busy_start_ignored", Busy, 1);
    Abort = 1'b1; tick(); Abort = 1'b0;
    check("abort_done", Done, 1);
    check("abort_error", Error, 1);
    repeat (2) tick();
    check("abort_count", wr_count - base_wr, 1);
    exp_q.push_back({BASE, 32'hCAFEF00D});
    do_start(1);
    send_byte(8'h0D, 0, 0); send_byte(8'hF0, 0, 0);
    send_byte(8'hFE, 0, 0); send_byte(8'hCA, 0, 0);
    ByteValid = 1'b0;
    wait_done();
    check("reload_error", Error, 0);
    check("reload_count", wr_count - base_wr, 2);

    // start and abort together while in WRITE: abort wins, no strobe
    base_wr = wr_count;
    do_start(2);
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
    ByteValid = 1'b0;
    check("wa_in_write", DbgState, S_WRITE);
    Abort = 1'b1; Start = 1'b1; WordCount = 16'd1;
    #1;
    check("wa_wren", WrEn, 0);
    tick();
    Abort = 1'b0; Start = 1'b0;
    check("wa_done", Done, 1);
    check("wa_error", Error, 1);
    check("wa_busy", Busy, 0);
    repeat (3) tick();
    check("wa_nowr", wr_count - base_wr, 0);

    // reset while in WRITE
    base_wr = wr_count;
    do_start(1);
    send_byte(8'h55, 0, 0); send_byte(8'h66, 0, 0);
    send_byte(8'h77, 0, 0); send_byte(8'h88, 0, 0);
    ByteValid = 1'b0;
    check("rw_in_write", DbgState, S_WRITE);
    Reset_L = 1'b0;
    #1;
    check("rw_wren", WrEn, 0);
    check("rw_busy", Busy, 0);
    check("rw_done", Done, 0);
    check("rw_error", Error, 0);
    check("rw_addr", WrAddr, BASE);
    check("rw_data", WrData, 0);
    check("rw_state", DbgState, S_IDLE);
    tick(); tick();
    Reset_L = 1'b1;
    repeat (8) tick();
    check("rw_nowr", wr_count - base_wr, 0);
    check("rw_idle", DbgState, S_IDLE);

    // random loads, then a full-capacity load
    for (int t = 0; t < 4; t++) load_words($urandom_range(1, 5), 2);
    base_wr = wr_count;
    load_words(64, 0);
    check("full_count", wr_count - base_wr, 64);
    check("full_last_addr", WrAddr, BASE + 64'hFC);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
